cnn_layer_sched: RTL and testbench
==================================

Name: cnn_layer_sched

Overview:
- Layer sequencer for the CNN accelerator; sits between the AHB control bus and the accelerator's layer config/start/done interface.
- Firmware loads a table of up to MAX_LAYERS layer descriptors, then writes RUN once.
- The block then drives each layer's config and base addresses, starts the layer, waits for its done, and advances to the next layer.
- It raises an interrupt after the last layer, removing per-layer CPU polling.

Parameters:
- W_ADDR, 32, AHB address width
- W_DATA, 32, AHB data width
- MAX_LAYERS, 8, descriptor table depth (power of 2)
- W_LIDX, $clog2(MAX_LAYERS), layer index width
- W_TMO, 24, watchdog counter width (SCHED_TIMEOUT_EN only)

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- sl_HSEL, sl_HREADY, sl_HWRITE  in  1 each  AHB-lite slave controls
- sl_HTRANS  in  2  transfer type
- sl_HADDR  in  W_ADDR  address
- sl_HWDATA  in  W_DATA  write data
- out_sl_HREADY  out  1  tied 1
- out_sl_HRESP  out  2  tied OKAY
- out_sl_HRDATA  out  W_DATA  read data (combinational from registered select)
- o_layer_cfg  out  32  LAYER_CONFIG word for the current layer
- o_base_addr  out  32  BASE_ADDRESS word for the current layer (weight [19:0], param [31:20])
- o_start  out  1  layer start level
- i_layer_done  in  1  accelerator end-of-frame flag
- o_irq  out  1  sequence complete / error interrupt, level

Behaviour:
- Address phase registers word select HADDR[6:2] and write enable when HSEL & HREADY & HTRANS is NONSEQ/SEQ. The write takes effect in the data phase.
- Register map (word offset):
  - 0 CTRL: W bit0 RUN, bit1 ABORT; reads 0.
  - 1 NUM_LAYERS: [W_LIDX:0], clamped to MAX_LAYERS on write.
  - 2 STATUS: RO; bit0 busy, bit1 done, bit2 aborted, bit3 timeout, [11:8] current index.
  - 3 IRQ_CLR: W1 clears o_irq, done, aborted, timeout.
  - 16+2i: descriptor i cfg; 17+2i: descriptor i base. Offsets beyond 2*MAX_LAYERS-1 read 0 and ignore writes.
- Descriptor and NUM_LAYERS writes while busy are ignored. CTRL RUN while busy is ignored.
- FSM states and transitions:
  - IDLE: on RUN, if num_layers==0, set done and o_irq (no o_start); else idx=0 and go to LOAD.
  - LOAD (1 cycle): register o_layer_cfg = desc_cfg[idx] with bit0 forced to (idx==0) and bit1 forced to (idx==num_layers-1); register o_base_addr = desc_base[idx]. Go to START.
  - START: o_start=1; stay until i_layer_done==1, then go to DRAIN.
  - DRAIN: o_start=0; stay until i_layer_done==0.
    - If idx==num_layers-1, go to DONE.
    - Else idx++ and go to LOAD.
  - DONE (1 cycle): set done and o_irq, clear busy, go to IDLE.
- Latency:
  - RUN data phase at edge T → LOAD at T+1 → o_start high after edge T+2.
  - i_layer_done sampled high at edge D → o_start low after D.
  - Next layer's o_start is high no earlier than 2 cycles after i_layer_done falls.
- busy = state ≠ IDLE.
- o_layer_cfg and o_base_addr hold their values until the next LOAD.
- ABORT in any non-IDLE state: next cycle IDLE, o_start=0, aborted=1, o_irq=1.
- ABORT and RUN in the same write: ABORT wins.
- ABORT while IDLE: no effect.
- i_layer_done already high on entry to START is honoured: advance after 1 cycle.
- IRQ_CLR coincident with DONE: set wins.
- Reset, including mid-sequence: all state and outputs 0, state IDLE, table contents 0, num_layers 0.

Optional Feature:
- Macro SCHED_TIMEOUT_EN.
- Defined:
  - Adds register 4 TMO_LIMIT (W_TMO bits, reset all-ones).
  - A counter runs in START/DRAIN and resets on each LOAD.
  - When count == TMO_LIMIT: force IDLE, o_start=0, timeout=1, o_irq=1.
  - Abort semantics apply otherwise.
- Undefined: no counter; offset 4 reads 0; STATUS bit3 is constant 0.

Decomposition:
- Shared package cnn_sched_pkg:
  - FSM state encoding.
  - Register offsets (CTRL, NUM_LAYERS, STATUS, IRQ_CLR, TMO_LIMIT, DESC_BASE=16).
  - STATUS bit positions.
  - Config bit positions FIRST=0, LAST=1.
- One sub-module cnn_sched_desc_ram: 2×MAX_LAYERS×32 register file, with one AHB write port, one AHB read port and one sequencer read port.

Test Plan:
- Reset → all outputs 0, STATUS=0, o_irq=0; read offset 16 returns 0.
- Load 3 descriptors (cfg 0x0000_000C/0x10/0x14, base 0x0010_0000/+0x400/+0x800), NUM_LAYERS=3, RUN, model raises done 50 cycles after start each layer → o_layer_cfg bit0=1 only layer0, bit1=1 only layer2; three o_start pulses; STATUS=0x2|idx2<<8; o_irq=1.
- NUM_LAYERS=0, RUN → no o_start, done=1 and o_irq=1 within 2 cycles; IRQ_CLR → o_irq=0.
- ABORT during layer1 START → o_start low next cycle, STATUS bit2=1, busy=0; descriptor write then accepted.
- Descriptor write and second RUN while busy → table unchanged, sequence unaffected; ABORT+RUN same word → aborted.
- (SCHED_TIMEOUT_EN) TMO_LIMIT=100, i_layer_done held 0 → at cycle 100 in START, timeout=1, o_irq=1, o_start=0.

Source files
------------

// File: rtl/cnn_sched_pkg.sv
// cnn_sched_pkg: shared types and constants for the CNN layer sequencer.
// FSM encoding, register word offsets, STATUS and LAYER_CONFIG bit positions.
package cnn_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DRAIN,
        S_DONE
    } sched_state_e;

    localparam logic [4:0] OFF_CTRL       = 5'd0;
    localparam logic [4:0] OFF_NUM_LAYERS = 5'd1;
    localparam logic [4:0] OFF_STATUS     = 5'd2;
    localparam logic [4:0] OFF_IRQ_CLR    = 5'd3;
    localparam logic [4:0] OFF_TMO_LIMIT  = 5'd4;
    localparam logic [4:0] OFF_DESC_BASE  = 5'd16;

    localparam int CTRL_RUN   = 0;
    localparam int CTRL_ABORT = 1;

    localparam int STS_BUSY    = 0;
    localparam int STS_DONE    = 1;
    localparam int STS_ABORTED = 2;
    localparam int STS_TIMEOUT = 3;
    localparam int STS_IDX_LSB = 8;

    localparam int CFG_FIRST = 0;
    localparam int CFG_LAST  = 1;

endpackage

// File: rtl/cnn_sched_desc_ram.sv
// cnn_sched_desc_ram: layer descriptor table, 2*MAX_LAYERS x 32 flops.
// Ports: AHB write (i_wr_*), AHB read (i_rd_addr/o_rd_data),
// sequencer read (i_seq_idx -> o_seq_cfg/o_seq_base). Even word = cfg, odd = base.
module cnn_sched_desc_ram #(
    parameter int MAX_LAYERS = 8,
    parameter int W_LIDX     = $clog2(MAX_LAYERS),
    parameter int W_RA       = $clog2(2 * MAX_LAYERS)
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              i_wr_en,
    input  logic [W_RA-1:0]   i_wr_addr,
    input  logic [31:0]       i_wr_data,
    input  logic [W_RA-1:0]   i_rd_addr,
    output logic [31:0]       o_rd_data,
    input  logic [W_LIDX-1:0] i_seq_idx,
    output logic [31:0]       o_seq_cfg,
    output logic [31:0]       o_seq_base
);

    logic [2*MAX_LAYERS-1:0][31:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (i_wr_en) begin
            mem_d[i_wr_addr] = i_wr_data;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign o_rd_data  = mem_q[i_rd_addr];
    assign o_seq_cfg  = mem_q[{i_seq_idx, 1'b0}];
    assign o_seq_base = mem_q[{i_seq_idx, 1'b1}];

endmodule

// File: rtl/cnn_layer_sched.sv
// cnn_layer_sched: AHB-lite programmable layer sequencer for the CNN accelerator.
// Ports: HCLK/HRESETn, AHB slave (sl_*, out_sl_*), layer side (o_layer_cfg,
// o_base_addr, o_start, i_layer_done), o_irq. Macro SCHED_TIMEOUT_EN adds a watchdog.
module cnn_layer_sched
    import cnn_sched_pkg::*;
#(
    parameter int W_ADDR     = 32,
    parameter int W_DATA     = 32,
    parameter int MAX_LAYERS = 8,
    parameter int W_LIDX     = $clog2(MAX_LAYERS),
    parameter int W_TMO      = 24
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              sl_HSEL,
    input  logic              sl_HREADY,
    input  logic              sl_HWRITE,
    input  logic [1:0]        sl_HTRANS,
    input  logic [W_ADDR-1:0] sl_HADDR,
    input  logic [W_DATA-1:0] sl_HWDATA,
    output logic              out_sl_HREADY,
    output logic [1:0]        out_sl_HRESP,
    output logic [W_DATA-1:0] out_sl_HRDATA,
    output logic [31:0]       o_layer_cfg,
    output logic [31:0]       o_base_addr,
    output logic              o_start,
    input  logic              i_layer_done,
    output logic              o_irq
);

    localparam int W_RA = $clog2(2 * MAX_LAYERS);
    localparam logic [W_LIDX:0] NUM_MAX = (W_LIDX + 1)'(MAX_LAYERS);

    logic [4:0]        addr_q, addr_d;
    logic              wr_q, wr_d;
    sched_state_e      state_q, state_d;
    logic [W_LIDX-1:0] idx_q, idx_d;
    logic [W_LIDX:0]   num_q, num_d;
    logic [31:0]       cfg_q, cfg_d;
    logic [31:0]       base_q, base_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              abrt_q, abrt_d;
    logic              irq_q, irq_d;
`ifdef SCHED_TIMEOUT_EN
    logic              tmo_q, tmo_d;
    logic [W_TMO-1:0]  lim_q, lim_d;
    logic [W_TMO-1:0]  cnt_q, cnt_d;
`else
    localparam int UNUSED_W_TMO = W_TMO;
`endif

    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic [31:0]     status;
    logic [31:0]     ram_rdata;
    logic [31:0]     seq_cfg;
    logic [31:0]     seq_base;
    logic [4:0]      desc_off;
    logic            desc_hit;
    logic            desc_we;
    logic            busy;
    logic            wr_ctrl;
    logic            run_req;
    logic            abort_req;
    logic            irq_clr;
    logic [W_LIDX:0] last_idx;
    logic            is_last;
    logic            unused_ok;

    assign wdata     = sl_HWDATA[31:0];
    assign busy      = (state_q != S_IDLE);
    assign desc_off  = addr_q - OFF_DESC_BASE;
    assign desc_hit  = (addr_q >= OFF_DESC_BASE) &&
                       ({1'b0, desc_off} < 6'(2 * MAX_LAYERS));
    assign desc_we   = wr_q && desc_hit && !busy;
    assign wr_ctrl   = wr_q && (addr_q == OFF_CTRL);
    assign run_req   = wr_ctrl && wdata[CTRL_RUN] && !wdata[CTRL_ABORT];
    assign abort_req = wr_ctrl && wdata[CTRL_ABORT];
    assign irq_clr   = wr_q && (addr_q == OFF_IRQ_CLR) && wdata[0];
    assign last_idx  = num_q - 1'b1;
    assign is_last   = ({1'b0, idx_q} == last_idx);
    assign unused_ok = ^{sl_HADDR[W_ADDR-1:7], sl_HADDR[1:0],
                         sl_HTRANS[0], desc_off[4:W_RA]};

    cnn_sched_desc_ram #(
        .MAX_LAYERS (MAX_LAYERS),
        .W_LIDX     (W_LIDX)
    ) u_desc_ram (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .i_wr_en    (desc_we),
        .i_wr_addr  (desc_off[W_RA-1:0]),
        .i_wr_data  (wdata),
        .i_rd_addr  (desc_off[W_RA-1:0]),
        .o_rd_data  (ram_rdata),
        .i_seq_idx  (idx_q),
        .o_seq_cfg  (seq_cfg),
        .o_seq_base (seq_base)
    );

    // Address phase capture; the write lands one cycle later with HWDATA.
    always_comb begin
        wr_d   = 1'b0;
        addr_d = addr_q;
        if (sl_HSEL && sl_HREADY && sl_HTRANS[1]) begin
            addr_d = sl_HADDR[6:2];
            wr_d   = sl_HWRITE;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        num_d   = num_q;
        cfg_d   = cfg_q;
        base_d  = base_q;
        start_d = start_q;
        done_d  = done_q;
        abrt_d  = abrt_q;
        irq_d   = irq_q;
`ifdef SCHED_TIMEOUT_EN
        tmo_d   = tmo_q;
        lim_d   = lim_q;
        cnt_d   = cnt_q;
        if (wr_q && (addr_q == OFF_TMO_LIMIT)) begin
            lim_d = wdata[W_TMO-1:0];
        end
`endif

        if (wr_q && (addr_q == OFF_NUM_LAYERS) && !busy) begin
            num_d = (wdata > 32'(MAX_LAYERS)) ? NUM_MAX : wdata[W_LIDX:0];
        end

        // Clears first so any set below in the same cycle wins.
        if (irq_clr) begin
            irq_d  = 1'b0;
            done_d = 1'b0;
            abrt_d = 1'b0;
`ifdef SCHED_TIMEOUT_EN
            tmo_d  = 1'b0;
`endif
        end

        unique case (state_q)
            S_IDLE: begin
                if (run_req) begin
                    if (num_q == '0) begin
                        done_d = 1'b1;
                        irq_d  = 1'b1;
                    end else begin
                        idx_d   = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                cfg_d            = seq_cfg;
                cfg_d[CFG_FIRST] = (idx_q == '0);
                cfg_d[CFG_LAST]  = is_last;
                base_d           = seq_base;
                start_d          = 1'b1;
                state_d          = S_START;
`ifdef SCHED_TIMEOUT_EN
                cnt_d            = '0;
`endif
            end
            S_START: begin
                if (i_layer_done) begin
                    start_d = 1'b0;
                    state_d = S_DRAIN;
                end
`ifdef SCHED_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
            end
            S_DRAIN: begin
                if (!i_layer_done) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
`ifdef SCHED_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
            end
            S_DONE: begin
                done_d  = 1'b1;
                irq_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SCHED_TIMEOUT_EN
        if (((state_q == S_START) || (state_q == S_DRAIN)) &&
            (cnt_q == lim_q)) begin
            state_d = S_IDLE;
            start_d = 1'b0;
            tmo_d   = 1'b1;
            irq_d   = 1'b1;
        end
`endif

        if (abort_req && busy) begin
            state_d = S_IDLE;
            start_d = 1'b0;
            abrt_d  = 1'b1;
            irq_d   = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            state_q <= S_IDLE;
            idx_q   <= '0;
            num_q   <= '0;
            cfg_q   <= '0;
            base_q  <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            abrt_q  <= 1'b0;
            irq_q   <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            tmo_q   <= 1'b0;
            lim_q   <= '1;
            cnt_q   <= '0;
`endif
        end else begin
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            cfg_q   <= cfg_d;
            base_q  <= base_d;
            start_q <= start_d;
            done_q  <= done_d;
            abrt_q  <= abrt_d;
            irq_q   <= irq_d;
`ifdef SCHED_TIMEOUT_EN
            tmo_q   <= tmo_d;
            lim_q   <= lim_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        status                     = '0;
        status[STS_BUSY]           = busy;
        status[STS_DONE]           = done_q;
        status[STS_ABORTED]        = abrt_q;
`ifdef SCHED_TIMEOUT_EN
        status[STS_TIMEOUT]        = tmo_q;
`endif
        status[STS_IDX_LSB +: 4]   = 4'(idx_q);

        rdata = '0;
        if (desc_hit) begin
            rdata = ram_rdata;
        end else begin
            case (addr_q)
                OFF_NUM_LAYERS: rdata = 32'(num_q);
                OFF_STATUS:     rdata = status;
`ifdef SCHED_TIMEOUT_EN
                OFF_TMO_LIMIT:  rdata = 32'(lim_q);
`endif
                default:        rdata = '0;
            endcase
        end
    end

    assign out_sl_HREADY = 1'b1;
    assign out_sl_HRESP  = 2'b00;
    assign out_sl_HRDATA = W_DATA'(rdata);
    assign o_layer_cfg   = cfg_q;
    assign o_base_addr   = base_q;
    assign o_start       = start_q;
    assign o_irq         = irq_q;

endmodule

// File: tb/tb_cnn_layer_sched.sv
// tb_cnn_layer_sched: directed self-checking bench for cnn_layer_sched.
// Drives AHB-lite writes/reads and models the accelerator's done flag.
module tb_cnn_layer_sched;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        sl_HSEL, sl_HREADY, sl_HWRITE;
    logic [1:0]  sl_HTRANS;
    logic [31:0] sl_HADDR, sl_HWDATA;
    logic        out_sl_HREADY;
    logic [1:0]  out_sl_HRESP;
    logic [31:0] out_sl_HRDATA;
    logic [31:0] o_layer_cfg, o_base_addr;
    logic        o_start, i_layer_done, o_irq;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_pulse = 0;
    logic start_prev = 1'b0;

    cnn_layer_sched dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .sl_HSEL       (sl_HSEL),
        .sl_HREADY     (sl_HREADY),
        .sl_HWRITE     (sl_HWRITE),
        .sl_HTRANS     (sl_HTRANS),
        .sl_HADDR      (sl_HADDR),
        .sl_HWDATA     (sl_HWDATA),
        .out_sl_HREADY (out_sl_HREADY),
        .out_sl_HRESP  (out_sl_HRESP),
        .out_sl_HRDATA (out_sl_HRDATA),
        .o_layer_cfg   (o_layer_cfg),
        .o_base_addr   (o_base_addr),
        .o_start       (o_start),
        .i_layer_done  (i_layer_done),
        .o_irq         (o_irq)
    );

    always #5 HCLK = ~HCLK;

    always @(negedge HCLK) begin
        if (o_start && !start_prev) n_pulse++;
        start_prev = o_start;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic ahb_wr(input int off, input logic [31:0] d);
        sl_HSEL   = 1'b1;
        sl_HTRANS = 2'b10;
        sl_HWRITE = 1'b1;
        sl_HADDR  = 32'(off) << 2;
        @(posedge HCLK); #1;
        sl_HSEL   = 1'b0;
        sl_HTRANS = 2'b00;
        sl_HWRITE = 1'b0;
        sl_HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic rd_chk(input string tag, input int off,
                          input logic [31:0] exp);
        sl_HSEL   = 1'b1;
        sl_HTRANS = 2'b10;
        sl_HWRITE = 1'b0;
        sl_HADDR  = 32'(off) << 2;
        @(posedge HCLK); #1;
        sl_HSEL   = 1'b0;
        sl_HTRANS = 2'b00;
        check(tag, out_sl_HRDATA, exp);
        @(posedge HCLK); #1;
    endtask

    task automatic wait_start(input logic lvl, input int bound);
        for (int i = 0; i < bound && o_start !== lvl; i++) begin
            @(posedge HCLK); #1;
        end
        check("wait_start", 32'(o_start), 32'(lvl));
    endtask

    task automatic do_layer(input logic [31:0] ecfg, input logic [31:0] ebase,
                            input int dly);
        wait_start(1'b1, 10);
        check("layer_cfg", o_layer_cfg, ecfg);
        check("layer_base", o_base_addr, ebase);
        repeat (dly) @(posedge HCLK);
        #1;
        i_layer_done = 1'b1;
        @(posedge HCLK); #1;
        check("start_fall", 32'(o_start), 32'd0);
        i_layer_done = 1'b0;
    endtask

    initial begin
        HRESETn      = 1'b0;
        sl_HSEL      = 1'b0;
        sl_HREADY    = 1'b1;
        sl_HWRITE    = 1'b0;
        sl_HTRANS    = 2'b00;
        sl_HADDR     = '0;
        sl_HWDATA    = '0;
        i_layer_done = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        check("rst_start", 32'(o_start), 32'd0);
        check("rst_irq", 32'(o_irq), 32'd0);
        check("rst_cfg", o_layer_cfg, 32'd0);
        check("rst_base", o_base_addr, 32'd0);
        check("hready", 32'(out_sl_HREADY), 32'd1);
        check("hresp", 32'(out_sl_HRESP), 32'd0);
        rd_chk("rst_status", 2, 32'h0);
        rd_chk("rst_desc0", 16, 32'h0);
        rd_chk("rst_num", 1, 32'h0);

        ahb_wr(16, 32'h0000_000C);
        ahb_wr(17, 32'h0010_0000);
        ahb_wr(18, 32'h0000_0010);
        ahb_wr(19, 32'h0010_0400);
        ahb_wr(20, 32'h0000_0014);
        ahb_wr(21, 32'h0010_0800);
        rd_chk("desc0_cfg", 16, 32'h0000_000C);
        rd_chk("desc2_base", 21, 32'h0010_0800);
        ahb_wr(1, 32'd20);
        rd_chk("num_clamp", 1, 32'd8);
        ahb_wr(1, 32'd3);
        rd_chk("num", 1, 32'd3);

        // Three-layer run with 50-cycle layers.
        ahb_wr(0, 32'h1);
        check("lat_load", 32'(o_start), 32'd0);
        @(posedge HCLK); #1;
        check("lat_start", 32'(o_start), 32'd1);
        do_layer(32'h0000_000D, 32'h0010_0000, 50);
        do_layer(32'h0000_0010, 32'h0010_0400, 50);
        do_layer(32'h0000_0016, 32'h0010_0800, 50);
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        check("seq_irq", 32'(o_irq), 32'd1);
        check("seq_pulses", 32'(n_pulse), 32'd3);
        check("cfg_hold", o_layer_cfg, 32'h0000_0016);
        rd_chk("seq_status", 2, 32'h0000_0202);
        ahb_wr(3, 32'h1);
        check("irq_clr", 32'(o_irq), 32'd0);
        rd_chk("clr_status", 2, 32'h0000_0200);

        // Zero layers: immediate done, no start.
        ahb_wr(1, 32'd0);
        ahb_wr(0, 32'h1);
        check("zero_irq", 32'(o_irq), 32'd1);
        repeat (3) @(posedge HCLK);
        #1;
        check("zero_nostart", 32'(n_pulse), 32'd3);
        rd_chk("zero_status", 2, 32'h0000_0202);
        ahb_wr(3, 32'h1);
        check("zero_clr", 32'(o_irq), 32'd0);

        // Busy writes ignored, then ABORT during layer 1.
        ahb_wr(1, 32'd3);
        ahb_wr(0, 32'h1);
        do_layer(32'h0000_000D, 32'h0010_0000, 5);
        wait_start(1'b1, 10);
        check("l1_cfg", o_layer_cfg, 32'h0000_0010);
        ahb_wr(18, 32'h0000_DEAD);
        ahb_wr(1, 32'd1);
        ahb_wr(0, 32'h1);
        check("busy_start", 32'(o_start), 32'd1);
        rd_chk("busy_status", 2, 32'h0000_0101);
        rd_chk("busy_desc1", 18, 32'h0000_0010);
        rd_chk("busy_num", 1, 32'd3);
        ahb_wr(0, 32'h2);
        check("abort_start", 32'(o_start), 32'd0);
        check("abort_irq", 32'(o_irq), 32'd1);
        rd_chk("abort_status", 2, 32'h0000_0104);
        ahb_wr(18, 32'h0000_0018);
        rd_chk("idle_desc_wr", 18, 32'h0000_0018);
        ahb_wr(3, 32'h1);

        // ABORT+RUN while idle does nothing; while busy it aborts.
        ahb_wr(0, 32'h3);
        repeat (3) @(posedge HCLK);
        #1;
        check("idle_ar_pulses", 32'(n_pulse), 32'd5);
        rd_chk("idle_ar_status", 2, 32'h0000_0100);
        ahb_wr(0, 32'h1);
        wait_start(1'b1, 10);
        ahb_wr(0, 32'h3);
        check("ar_start", 32'(o_start), 32'd0);
        rd_chk("ar_status", 2, 32'h0000_0004);
        ahb_wr(3, 32'h1);

        // Single layer with done already high on entry to START.
        ahb_wr(1, 32'd1);
        i_layer_done = 1'b1;
        ahb_wr(0, 32'h1);
        @(posedge HCLK); #1;
        check("pre_start", 32'(o_start), 32'd1);
        check("pre_cfg", o_layer_cfg, 32'h0000_000F);
        @(posedge HCLK); #1;
        check("pre_drain", 32'(o_start), 32'd0);
        i_layer_done = 1'b0;
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        check("pre_irq", 32'(o_irq), 32'd1);
        rd_chk("pre_status", 2, 32'h0000_0002);
        ahb_wr(3, 32'h1);

`ifdef SCHED_TIMEOUT_EN
        rd_chk("tmo_rst", 4, 32'h00FF_FFFF);
        ahb_wr(4, 32'd100);
        ahb_wr(0, 32'h1);
        wait_start(1'b1, 10);
        begin
            int n;
            n = 0;
            while (o_start && n < 300) begin
                @(posedge HCLK); #1;
                n++;
            end
            check("tmo_cycles", 32'(n), 32'd101);
        end
        check("tmo_irq", 32'(o_irq), 32'd1);
        rd_chk("tmo_status", 2, 32'h0000_0008);
`else
        rd_chk("tmo_absent", 4, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
